// File: rtl/cpu_mux_pkg.sv
// Shared CPU datapath mux definitions: select-width helper and the
// forwarding-source select encodings used by the hazard unit.
package cpu_mux_pkg;

  // Forwarding source codes driven by the hazard unit.
  typedef enum logic [1:0] {
    SEL_RF = 2'd0,  // register file read
    SEL_EM = 2'd1,  // EX/MEM forward
    SEL_MW = 2'd2   // MEM/WB forward
  } fwd_sel_e;

  // Binary select width for n inputs; never below one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One register slice {valid, err, data} of the selector pipeline.
// Priority on each edge: reset > flush > stall (hold) > load.
module mux_pipe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         stall,
  input  logic [W+1:0] d_i,
  output logic [W+1:0] q_o
);

  logic [W+1:0] slice_q, slice_d;

  // Next slice value: flush clears, stall holds, otherwise load upstream.
  always_comb begin
    slice_d = slice_q;
    if (flush)       slice_d = '0;
    else if (!stall) slice_d = d_i;
  end

  // Slice register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) slice_q <= '0;
    else       slice_q <= slice_d;
  end

  assign q_o = slice_q;

endmodule

// File: rtl/mux_pipe.sv
// Pipelined N-way selector with valid/err tracking, stall and flush.
// Out-of-range selects yield DEFAULT_VAL and a qualified error flag.
module mux_pipe
  import cpu_mux_pkg::*;
#(
  parameter int              W           = 32,
  parameter int              N_IN        = 4,
  parameter int              LATENCY     = 1,
  parameter longint unsigned DEFAULT_VAL = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_IN*W-1:0]            in_bus,
  input  logic [sel_width(N_IN)-1:0]   slt,
  input  logic                         in_valid,
  input  logic                         stall,
  input  logic                         flush,
  output logic [W-1:0]                 out,
  output logic                         out_valid,
  output logic                         out_err
);

  localparam int           SW    = sel_width(N_IN);
  localparam int           NCODE = 1 << SW;
  localparam logic [W-1:0] DEF   = W'(DEFAULT_VAL);

  // Full decode table over every select code; unused codes map to the
  // default value and set the out-of-range flag.
  logic [W-1:0]     sel_tab [NCODE];
  logic [NCODE-1:0] oor_tab;

  for (genvar k = 0; k < NCODE; k++) begin : g_tab
    if (k < N_IN) begin : g_in
      assign sel_tab[k] = in_bus[k*W +: W];
      assign oor_tab[k] = 1'b0;
    end else begin : g_def
      assign sel_tab[k] = DEF;
      assign oor_tab[k] = 1'b1;
    end
  end

  logic [W-1:0] sel_data;
  logic         sel_err;

  assign sel_data = sel_tab[slt];
  assign sel_err  = oor_tab[slt] & in_valid;

  // stg_pipe[0] is the combinational front end; stg_pipe[i+1] is slice i.
  logic [W+1:0] stg_pipe [LATENCY+1];

  assign stg_pipe[0] = {in_valid, sel_err, sel_data};

  for (genvar i = 0; i < LATENCY; i++) begin : g_stg
    mux_pipe_stage #(.W(W)) u_stg (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .stall (stall),
      .d_i   (stg_pipe[i]),
      .q_o   (stg_pipe[i+1])
    );
  end

  assign {out_valid, out_err, out} = stg_pipe[LATENCY];

endmodule

// File: tb/tb_mux_pipe.sv
// Scoreboard bench for mux_pipe: W=32, N_IN=3, LATENCY=3, default 0xDEADBEEF.
module tb_mux_pipe;

  localparam int          W   = 32;
  localparam int          NI  = 3;
  localparam int          LAT = 3;
  localparam logic [31:0] DEF = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NI*W-1:0]   in_bus;
  logic [1:0]        slt = '0;
  logic              in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [W-1:0]      out;
  logic              out_valid, out_err;
  logic [W-1:0]      ops [NI];

  assign in_bus = {ops[2], ops[1], ops[0]};

  mux_pipe #(.W(W), .N_IN(NI), .LATENCY(LAT), .DEFAULT_VAL(64'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset), .in_bus(in_bus), .slt(slt), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out), .out_valid(out_valid), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          e;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   adv = 0;       // count of edges on which the pipeline advanced
  bit   zero_chk = 0;  // last effective edge was reset/flush
  int   errs = 0, checks = 0;

  function automatic logic [31:0] ref_sel(input logic [1:0] s);
    if (int'(s) < NI) return ops[s];
    return DEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: what each edge does to the set of in-flight items.
  initial forever begin
    @(posedge clk);
    if (reset || flush) begin
      sb.delete();
      zero_chk = 1;
    end else if (!stall) begin
      adv++;
      zero_chk = 0;
      if (in_valid) sb.push_back('{ref_sel(slt), (int'(slt) >= NI), adv + LAT - 1});
    end
  end

  // Monitor: compare the presented outputs against the scoreboard head.
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due < adv) void'(sb.pop_front());
    if (zero_chk) begin
      chk("clear_out",   out,             32'h0);
      chk("clear_valid", {31'h0, out_valid}, 32'h0);
      chk("clear_err",   {31'h0, out_err},   32'h0);
    end else if (sb.size() > 0 && sb[0].due == adv) begin
      chk("valid", {31'h0, out_valid}, 32'h1);
      chk("data",  out,                sb[0].d);
      chk("err",   {31'h0, out_err},   {31'h0, sb[0].e});
    end else begin
      chk("idle_valid", {31'h0, out_valid}, 32'h0);
      chk("idle_err",   {31'h0, out_err},   32'h0);
    end
  end

  task automatic step(input bit v, input logic [1:0] s,
                      input bit st = 0, input bit fl = 0, input bit rs = 0);
    for (int k = 0; k < NI; k++) ops[k] = $urandom;
    in_valid = v; slt = s; stall = st; flush = fl; reset = rs;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 2'($urandom_range(0, 3)));
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // basic select with the fixed operand pattern
    ops[0] = 32'h1111_1111; ops[1] = 32'h2222_2222; ops[2] = 32'h3333_3333;
    in_valid = 1; slt = 1; stall = 0; flush = 0; reset = 0;
    @(negedge clk); #1;
    idle(LAT);
    // out-of-range select
    step(1, 3); idle(LAT);
    // back-to-back stream
    step(1, 0); step(1, 1); step(1, 2); step(1, 0); idle(LAT);
    // two items in flight, two stall cycles with a dropped input
    step(1, 0); step(1, 1);
    step(1, 2, 1); step(1, 3, 1);
    idle(LAT + 1);
    // flush and stall together with all stages valid
    step(1, 0); step(1, 1); step(1, 2);
    step(1, 0, 1, 1);
    idle(2);
    // reset mid-stream, then a fresh item
    step(1, 1); step(1, 2);
    step(1, 0, 0, 0, 1);
    step(1, 2); idle(LAT + 1);
    // select changes with in_valid low
    step(0, 3); step(0, 1); step(0, 3); idle(LAT);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      automatic int r = $urandom_range(0, 99);
      step(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 2), (r < 5), (r >= 97));
    end
    idle(LAT + 2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
